// File: rtl/aes_key_sched_pkg.sv
// Shared AES definitions: key-schedule FSM states, AES-128 constants and GF(2^8) helpers.
package aes_key_sched_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    SUB  = 3'd2,
    EXP  = 3'd3,
    EMIT = 3'd4
  } ks_state_e;

  localparam logic [3:0] AES_NR    = 4'd10;
  localparam logic [7:0] RCON_INIT = 8'h01;

  // Multiply by x in GF(2^8) modulo the AES polynomial; also used by MixColumns.
  function automatic logic [7:0] xtime(input logic [7:0] x);
    xtime = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    rot_word = {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_key_sched_s4.sv
// Registered four-byte AES S-box: out takes SubWord(in) one cycle after in is presented.
module s4 (
  input  logic        clk,
  input  logic [31:0] in,
  output logic [31:0] out
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Per-byte substitution, registered.
  always_ff @(posedge clk) begin
    out <= {SBOX[in[31:24]], SBOX[in[23:16]], SBOX[in[15:8]], SBOX[in[7:0]]};
  end

endmodule

// File: rtl/aes_key_sched.sv
// Iterative AES-128 key expansion: emits round keys 0..10, one every three cycles,
// sharing a registered S4 so each step spans a SUB and an EXP cycle.
module aes_key_sched
  import aes_key_sched_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic         ready,
  output logic         rk_valid,
  output logic [3:0]   rk_round,
  output logic [127:0] rk_out,
  output logic         done
);

  ks_state_e    state_r;
  ks_state_e    state_nxt_s;
  logic [127:0] key_r;
  logic [3:0]   round_r;
  logic [7:0]   rcon_r;
  logic         ready_r;
  logic         valid_r;
  logic         done_r;
  logic [3:0]   rk_round_r;
  logic [127:0] rk_out_r;

  logic         accept_s;
  logic         load_s;
  logic         exp_s;
  logic         emit_s;
  logic         last_s;
  logic [31:0]  s4_in_s;
  logic [31:0]  s4_out_s;
  logic [31:0]  t_s;
  logic [31:0]  w0_s;
  logic [31:0]  w1_s;
  logic [31:0]  w2_s;
  logic [31:0]  w3_s;

  // The S4 input is stable across SUB and EXP because key_r only changes at the end of EXP.
  assign s4_in_s = rot_word(key_r[31:0]);

  s4 u_s4 (
    .clk (clk),
    .in  (s4_in_s),
    .out (s4_out_s)
  );

  assign t_s  = s4_out_s ^ {rcon_r, 24'h000000};
  assign w0_s = key_r[127:96] ^ t_s;
  assign w1_s = key_r[95:64]  ^ w0_s;
  assign w2_s = key_r[63:32]  ^ w1_s;
  assign w3_s = key_r[31:0]   ^ w2_s;

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state and per-state control strobes.
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    load_s      = 1'b0;
    exp_s       = 1'b0;
    emit_s      = 1'b0;
    last_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (ready_r && start) begin
          accept_s    = 1'b1;
          state_nxt_s = LOAD;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      LOAD: begin
        load_s      = 1'b1;
        state_nxt_s = SUB;
      end
      SUB: begin
        state_nxt_s = EXP;
      end
      EXP: begin
        exp_s       = 1'b1;
        state_nxt_s = EMIT;
      end
      EMIT: begin
        emit_s = 1'b1;
        if (round_r == AES_NR) begin
          last_s      = 1'b1;
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = SUB;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Working key, round counter and rcon.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_r   <= 128'd0;
      round_r <= 4'd0;
      rcon_r  <= RCON_INIT;
    end else if (accept_s) begin
      key_r   <= key_in;
      round_r <= 4'd0;
      rcon_r  <= RCON_INIT;
    end else if (exp_s) begin
      key_r   <= {w0_s, w1_s, w2_s, w3_s};
      round_r <= round_r + 4'd1;
      rcon_r  <= xtime(rcon_r);
    end else begin
      key_r   <= key_r;
      round_r <= round_r;
      rcon_r  <= rcon_r;
    end
  end

  // Registered outputs; ready rises one cycle after returning to IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_r    <= 1'b1;
      valid_r    <= 1'b0;
      done_r     <= 1'b0;
      rk_round_r <= 4'd0;
      rk_out_r   <= 128'd0;
    end else begin
      ready_r <= (state_r == IDLE) && !accept_s;
      valid_r <= load_s || emit_s;
      done_r  <= last_s;
      if (load_s || emit_s) begin
        rk_round_r <= round_r;
        rk_out_r   <= key_r;
      end else begin
        rk_round_r <= rk_round_r;
        rk_out_r   <= rk_out_r;
      end
    end
  end

  assign ready    = ready_r;
  assign rk_valid = valid_r;
  assign done     = done_r;
  assign rk_round = rk_round_r;
  assign rk_out   = rk_out_r;

endmodule
